// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with 2-entry skid buffer acting as EX/MEM register.
// The ALU result is computed combinationally and captured at push; MEM drains the head.
// Optional macro EX_FWD_EN enables the ALU-result forwarding tap toward the ID bypass mux.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alua,
    input  logic [31:0] alub,
    input  logic [2:0]  alu_sel,
    input  logic        dram_wen,
    input  logic        rf_wen,
    input  logic [31:0] data2,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_res_o,
    output logic [31:0] data2_o,
    output logic [31:0] pc4_o,
    output logic [31:0] imm_o,
    output logic        dram_wen_o,
    output logic        rf_wen_o,
    output logic [1:0]  wb_sel_o,
    output logic [4:0]  wb_addr_o,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data
);

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] data2;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        dram_wen;
        logic        rf_wen;
        logic [1:0]  wb_sel;
        logic [4:0]  wb_addr;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e      r_state;
    entry_t      r_slot0;  // head
    entry_t      r_slot1;  // skid
    entry_t      w_new;
    entry_t      w_head;
    logic [31:0] w_alu_res;
    logic [4:0]  w_shamt;
    logic        w_push;
    logic        w_pop;

    assign in_ready  = (r_state != StTwo);
    assign out_valid = (r_state != StEmpty);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_shamt   = alub[4:0];

    // ALU on the incoming operands
    always_comb begin
        w_alu_res = '0;
        case (alu_sel)
            3'b000:  w_alu_res = alua + alub;
            3'b001:  w_alu_res = alua - alub;
            3'b010:  w_alu_res = alua & alub;
            3'b011:  w_alu_res = alua | alub;
            3'b100:  w_alu_res = alua ^ alub;
            3'b101:  w_alu_res = alua << w_shamt;
            3'b110:  w_alu_res = alua >> w_shamt;
            default: w_alu_res = $signed(alua) >>> w_shamt;
        endcase
    end

    assign w_new = {w_alu_res, data2, pc + 32'd4, imm, dram_wen, rf_wen, wb_sel, wb_addr};

    // Buffer occupancy FSM and slot storage; flush drops everything incl. a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (flush) begin
            r_state <= StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_push) begin
                        r_slot0 <= w_new;
                        r_state <= StOne;
                    end
                end
                StOne: begin
                    if (w_push && w_pop) begin
                        r_slot0 <= w_new;
                    end else if (w_push) begin
                        r_slot1 <= w_new;
                        r_state <= StTwo;
                    end else if (w_pop) begin
                        r_state <= StEmpty;
                    end
                end
                StTwo: begin
                    if (w_pop) begin
                        r_slot0 <= r_slot1;
                        r_state <= StOne;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    // Head fields read as zero whenever the buffer is empty
    always_comb begin
        w_head = out_valid ? r_slot0 : '0;
    end

    assign alu_res_o  = w_head.alu_res;
    assign data2_o    = w_head.data2;
    assign pc4_o      = w_head.pc4;
    assign imm_o      = w_head.imm;
    assign dram_wen_o = w_head.dram_wen;
    assign rf_wen_o   = w_head.rf_wen;
    assign wb_sel_o   = w_head.wb_sel;
    assign wb_addr_o  = w_head.wb_addr;

`ifdef EX_FWD_EN
    logic w_fwd_hit;

    // Forward only ALU-sourced register writes to a non-zero destination
    always_comb begin
        w_fwd_hit = out_valid & w_head.rf_wen & (w_head.wb_sel == 2'b00) &
                    (w_head.wb_addr != 5'd0);
    end

    assign fwd_valid = w_fwd_hit;
    assign fwd_addr  = w_fwd_hit ? w_head.wb_addr : 5'd0;
    assign fwd_data  = w_fwd_hit ? w_head.alu_res : 32'd0;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = 5'd0;
    assign fwd_data  = 32'd0;
`endif

endmodule
